// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// INSTR_NOP is the canonical ADDI x0,x0,0 encoding; the fetch path never emits it.
package fetch_sequencer_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000013;

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction/PC buffer that parks a response while decode is stalled.
module fetch_skid_buf
    import fetch_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [XLEN-1:0] push_instr,
    input  logic [XLEN-1:0] push_pc,
    input  logic            pop,
    input  logic            clear,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (push) begin
            valid_q <= 1'b1;
            instr_q <= push_instr;
            pc_q    <= push_pc;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: single-outstanding imem requests, redirect/kill
// handling and the IF/ID pipeline register.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        misalign
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            kill_q, kill_d;

    logic            if_valid_q;
    logic [XLEN-1:0] if_instr_q;
    logic [XLEN-1:0] if_pc_q;
    logic [XLEN-1:0] if_pc_plus4_q;

    logic            ifid_free;
    logic            ifid_load;
    logic [XLEN-1:0] ifid_load_instr;
    logic [XLEN-1:0] ifid_load_pc;
    logic [XLEN-1:0] redirect_target;

    logic            buf_push;
    logic            buf_pop;
    logic            buf_clear;
    logic            buf_valid;
    logic [XLEN-1:0] buf_instr;
    logic [XLEN-1:0] buf_pc;

    assign redirect_target = align_word(redirect_pc);
    assign ifid_free       = !if_valid_q || !stall_d;

    assign imem_req  = !rst && (state_q == StReq) && !redirect_valid;
    assign imem_addr = pc_q;
    assign misalign  = !rst && redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        fetch_pc_d      = fetch_pc_q;
        kill_d          = kill_q;
        buf_push        = 1'b0;
        buf_pop         = 1'b0;
        buf_clear       = 1'b0;
        ifid_load       = 1'b0;
        ifid_load_instr = '0;
        ifid_load_pc    = '0;

        unique case (state_q)
            StReq: begin
                // Post-reset kill only needs to cover the first cycle in REQ.
                kill_d = 1'b0;
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end else if (imem_ready) begin
                    state_d    = StWait;
                    pc_d       = pc_q + 32'd4;
                    fetch_pc_d = pc_q;
                end
            end
            StWait: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (imem_rvalid) begin
                        state_d = StReq;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    state_d = StReq;
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else if (ifid_free) begin
                        ifid_load       = 1'b1;
                        ifid_load_instr = imem_rdata;
                        ifid_load_pc    = fetch_pc_q;
                    end else begin
                        buf_push = 1'b1;
                        state_d  = StHold;
                    end
                end
            end
            StHold: begin
                if (redirect_valid) begin
                    buf_clear = 1'b1;
                    pc_d      = redirect_target;
                    state_d   = StReq;
                end else if (!stall_d) begin
                    buf_pop         = 1'b1;
                    ifid_load       = buf_valid;
                    ifid_load_instr = buf_instr;
                    ifid_load_pc    = buf_pc;
                    state_d         = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StReq;
            pc_q       <= RESET_PC;
            fetch_pc_q <= '0;
            // A response still in flight when reset hits must not reach IF/ID.
            kill_q     <= (state_q == StWait);
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            kill_q     <= kill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
        end else if (redirect_valid) begin
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
        end else if (ifid_load) begin
            if_valid_q    <= 1'b1;
            if_instr_q    <= ifid_load_instr;
            if_pc_q       <= ifid_load_pc;
            if_pc_plus4_q <= ifid_load_pc + 32'd4;
        end else if (!stall_d) begin
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;

    fetch_skid_buf u_skid_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (buf_push),
        .push_instr (imem_rdata),
        .push_pc    (fetch_pc_q),
        .pop        (buf_pop),
        .clear      (buf_clear),
        .valid      (buf_valid),
        .instr      (buf_instr),
        .pc         (buf_pc)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; the bench acts as instruction memory and
// queues each response it expects to reach IF/ID.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        misalign;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    fetch_sequencer #(
        .RESET_PC (32'h00000000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_d        (stall_d),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .misalign       (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic respond(input logic [31:0] pc, input logic [31:0] data, input bit keep);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        if (keep) sb_q.push_back('{pc: pc, instr: data});
    endtask

    task automatic expect_ifid(input string tag);
        sb_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_has_entry"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, 32'(if_valid), 32'd1);
            chk({tag, "_pc"}, if_pc, e.pc);
            chk({tag, "_instr"}, if_instr, e.instr);
            chk({tag, "_plus4"}, if_pc_plus4, e.pc + 32'd4);
        end
    endtask

    task automatic expect_req(input string tag, input logic [31:0] addr);
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, imem_addr, addr);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000102;
        stall_d        = 1'b0;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;

        // Reset: outputs quiet even with a misaligned redirect presented
        tick();
        settle();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_pc_plus4", if_pc_plus4, 32'd0);
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick();
        rst = 1'b0;
        settle();

        // Sequential fetch 0, 4, 8
        expect_req("f0", 32'h0);
        tick();
        settle();
        chk("f0_one_outstanding", 32'(imem_req), 32'd0);
        respond(32'h0, 32'h11110001, 1'b1);
        tick();
        imem_rvalid = 1'b0;
        settle();
        expect_ifid("f0_ifid");
        expect_req("f4", 32'h4);
        tick();
        respond(32'h4, 32'h22220002, 1'b1);
        tick();
        imem_rvalid = 1'b0;
        settle();
        expect_ifid("f4_ifid");
        expect_req("f8", 32'h8);

        // Stall while PC 8 returns: HOLD, no new request, IF/ID held
        stall_d = 1'b1;
        tick();
        respond(32'h8, 32'h00500093, 1'b1);
        tick();
        imem_rvalid = 1'b0;
        settle();
        chk("hold_req", 32'(imem_req), 32'd0);
        chk("hold_if_pc", if_pc, 32'h4);
        chk("hold_if_instr", if_instr, 32'h22220002);
        chk("hold_if_plus4", if_pc_plus4, 32'h8);
        tick();
        settle();
        chk("hold_req2", 32'(imem_req), 32'd0);
        stall_d = 1'b0;
        tick();
        settle();
        expect_ifid("hold_drain");
        expect_req("f12", 32'hC);

        // Redirect in WAIT: stale response dropped, refetch at 0x100
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000100;
        settle();
        chk("wait_redir_misalign", 32'(misalign), 32'd0);
        tick();
        redirect_valid = 1'b0;
        respond(32'hC, 32'hDEAD0001, 1'b0);
        tick();
        imem_rvalid = 1'b0;
        settle();
        chk("kill_if_valid", 32'(if_valid), 32'd0);
        expect_req("redir_f100", 32'h100);
        tick();
        respond(32'h100, 32'h33330003, 1'b1);
        tick();
        imem_rvalid = 1'b0;
        settle();
        expect_ifid("redir_ifid");
        expect_req("f104", 32'h104);

        // Redirect + stall + rvalid in the same cycle
        stall_d = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000100;
        respond(32'h104, 32'hDEAD0002, 1'b0);
        tick();
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        settle();
        chk("combo_if_valid", 32'(if_valid), 32'd0);
        chk("combo_if_instr", if_instr, 32'd0);
        expect_req("combo_f100", 32'h100);
        tick();
        respond(32'h100, 32'h44440004, 1'b1);
        tick();
        imem_rvalid = 1'b0;
        settle();
        expect_ifid("combo_ifid");
        stall_d = 1'b0;
        settle();
        expect_req("combo_no_hold", 32'h104);

        // Misaligned redirect, then wrap from 0xFFFFFFFC
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000102;
        settle();
        chk("mis_pulse", 32'(misalign), 32'd1);
        chk("mis_req_forced", 32'(imem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
        settle();
        chk("mis_pulse_end", 32'(misalign), 32'd0);
        chk("mis_if_valid", 32'(if_valid), 32'd0);
        expect_req("mis_aligned", 32'h100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFFFFFC;
        settle();
        chk("wrap_redir_misalign", 32'(misalign), 32'd0);
        tick();
        redirect_valid = 1'b0;
        settle();
        expect_req("wrap_top", 32'hFFFFFFFC);
        tick();
        respond(32'hFFFFFFFC, 32'h55550005, 1'b1);
        tick();
        imem_rvalid = 1'b0;
        settle();
        expect_ifid("wrap_ifid");
        expect_req("wrap_zero", 32'h0);

        // Reset while a request is outstanding; late response dropped
        tick();
        rst = 1'b1;
        settle();
        chk("rst_wait_req", 32'(imem_req), 32'd0);
        tick();
        rst         = 1'b0;
        imem_ready  = 1'b0;
        respond(32'h0, 32'hDEAD0003, 1'b0);
        settle();
        chk("rst_late_if_valid", 32'(if_valid), 32'd0);
        expect_req("rst_first", 32'h0);
        tick();
        imem_rvalid = 1'b0;
        imem_ready  = 1'b1;
        settle();
        chk("rst_late_dropped", 32'(if_valid), 32'd0);
        chk("rst_late_instr", if_instr, 32'd0);
        expect_req("rst_refetch", 32'h0);
        tick();
        respond(32'h0, 32'h66660006, 1'b1);
        tick();
        imem_rvalid = 1'b0;
        settle();
        expect_ifid("rst_ifid");
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
